// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: stall bus layout,
// divider FSM state encoding, stall patterns and the stall-cause enum.
package pipe_stall_ctrl_pkg;

    localparam int STALL_W = 6;

    // Bit order: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Thermometer patterns; the first unstopped stage receives a bubble.
    localparam stall_bus_t STALL_NONE = {6{NO_STOP}};
    localparam stall_bus_t STALL_LU   = {{3{NO_STOP}}, {3{STOP}}};
    localparam stall_bus_t STALL_DIV  = {{2{NO_STOP}}, {4{STOP}}};
    localparam stall_bus_t STALL_MEM  = {{1{NO_STOP}}, {5{STOP}}};

    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_FLUSH = 3'd1,
        CAUSE_MEM   = 3'd2,
        CAUSE_DIV   = 3'd3,
        CAUSE_LU    = 3'd4
    } stall_cause_t;

    function automatic stall_bus_t stall_pattern(input stall_cause_t cause);
        case (cause)
            CAUSE_MEM: return STALL_MEM;
            CAUSE_DIV: return STALL_DIV;
            CAUSE_LU:  return STALL_LU;
            default:   return STALL_NONE;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall
// sequencer.
//
// Handshake: every request is a level held by its stage for as long as the
// condition exists. ex_div_start acts as "valid" for a divide and must stay
// high until the cycle in which div_ready ("ready") is seen high; EX drops
// it on that cycle. div_ready stays high while MEM stalls so EX can latch
// the result once it advances. flush_req overrides everything that cycle.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 6
);
    import pipe_stall_ctrl_pkg::*;

    logic             id_stallreq;
    logic             ex_div_start;
    logic             mem_stallreq;
    logic             flush_req;
    stall_bus_t       stall;
    logic             flush;
    logic             div_busy;
    logic             div_ready;
    logic [CNT_W-1:0] div_cnt;
    div_state_t       div_state;   // debug view of the divider FSM

    // Pipeline side: raises requests, consumes stall/flush.
    modport master (
        output id_stallreq, ex_div_start, mem_stallreq, flush_req,
        input  stall, flush, div_busy, div_ready, div_cnt, div_state
    );

    // Sequencer side.
    modport slave (
        input  id_stallreq, ex_div_start, mem_stallreq, flush_req,
        output stall, flush, div_busy, div_ready, div_cnt, div_state
    );

endinterface

// File: rtl/pipe_stall_ctrl_div_seq_fsm.sv
// Divider sequencing FSM: counts DIV_CYCLES busy cycles, then holds the
// result-valid state until MEM stops stalling. Flush aborts from any state.
module pipe_stall_ctrl_div_seq_fsm
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6    // 2**CNT_W must exceed DIV_CYCLES
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start,
    input  logic             mem_stallreq,
    input  logic             flush_req,
    output div_state_t       state,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    // State, counter and registered busy/ready flags advance together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else if (flush_req) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        state <= BUSY;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    // Keeps counting through mem stalls; the divider is independent.
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // div_start is still asserted by the same instruction; ignore it.
                    if (!mem_stallreq) begin
                        state <= IDLE;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Priority-encodes
// the stall requests into the thermometer stall bus and hosts the divider
// sequencing FSM. Optional stall-cause performance counters are built when
// PIPE_STALL_PERF_EN is defined.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic               clk,
    input  logic               resetn,
    pipe_stall_ctrl_if.slave   bus
`ifdef PIPE_STALL_PERF_EN
    ,
    output logic [31:0]        perf_div_stall,
    output logic [31:0]        perf_mem_stall,
    output logic [31:0]        perf_lu_stall
`endif
);

    stall_cause_t cause;

    pipe_stall_ctrl_div_seq_fsm #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_seq_fsm (
        .clk          (clk),
        .resetn       (resetn),
        .div_start    (bus.ex_div_start),
        .mem_stallreq (bus.mem_stallreq),
        .flush_req    (bus.flush_req),
        .state        (bus.div_state),
        .cnt          (bus.div_cnt),
        .busy         (bus.div_busy),
        .ready        (bus.div_ready)
    );

    // Pick the single winning stall cause; the start cycle of a divide already stalls.
    always_comb begin
        cause = CAUSE_NONE;
        if (bus.flush_req) begin
            cause = CAUSE_FLUSH;
        end else if (bus.mem_stallreq) begin
            cause = CAUSE_MEM;
        end else if (bus.div_state == BUSY ||
                     (bus.div_state == IDLE && bus.ex_div_start)) begin
            cause = CAUSE_DIV;
        end else if (bus.id_stallreq) begin
            cause = CAUSE_LU;
        end
    end

    // Outputs are forced quiet while reset is held, whatever the requests say.
    assign bus.stall = resetn ? stall_pattern(cause) : STALL_NONE;
    assign bus.flush = resetn & bus.flush_req;

`ifdef PIPE_STALL_PERF_EN
    // Saturating per-cause stall cycle counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_div_stall <= '0;
            perf_mem_stall <= '0;
            perf_lu_stall  <= '0;
        end else begin
            if (cause == CAUSE_DIV) perf_div_stall <= sat_inc32(perf_div_stall);
            if (cause == CAUSE_MEM) perf_mem_stall <= sat_inc32(perf_mem_stall);
            if (cause == CAUSE_LU)  perf_lu_stall  <= sat_inc32(perf_lu_stall);
        end
    end
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB). Collects stall requests from ID (load-use), EX (multi-cycle divider) and MEM (data SRAM wait). Drives the shared `StallBus` vector consumed by every stage register, including the WB stage's bubble-insert rule (stage k stopped, stage k+1 not stopped → bubble). Owns the divider sequencing FSM and its cycle counter.

Parameters:
- DIV_CYCLES, 32, number of busy cycles the iterative divider needs before its result is valid.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  input  1  pipeline clock
- resetn  input  1  asynchronous active-low reset
- id_stallreq  input  1  load-use hazard detected in ID
- ex_div_start  input  1  div/divu present in EX and not yet completed; held high by EX until div_ready
- mem_stallreq  input  1  MEM waiting on data SRAM data_ok
- flush_req  input  1  exception/eret flush request from MEM
- stall  output  `StallBus` (6)  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1=`Stop`
- flush  output  1  flush to all stage registers
- div_busy  output  1  divider FSM in BUSY
- div_ready  output  1  divider result valid for EX to latch
- div_cnt  output  CNT_W  current busy-cycle count

Behaviour:
- Reset: asynchronous on resetn low.
  - FSM=IDLE, div_cnt=0.
  - All outputs are 0 while resetn is low: stall=6'b000000, flush=0, div_busy=0, div_ready=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY when ex_div_start=1 and flush_req=0; div_cnt←0.
  - BUSY: div_cnt increments every cycle, including during a mem stall. When div_cnt==DIV_CYCLES-1, go to DONE and clear div_cnt.
  - DONE: div_ready=1. Go to IDLE on the first cycle with mem_stallreq=0. While mem_stallreq=1, stay in DONE so the result is held until EX can advance.
  - In DONE, ex_div_start is ignored; the same instruction is still presenting it.
  - Any state→IDLE when flush_req=1 (divide aborted, div_cnt←0). Flush has priority over all other transitions.
- Stall vector: combinational from FSM state and requests. Highest-priority source wins:
  1. flush_req=1 → stall=000000, flush=1.
  2. mem_stallreq=1 → stall=011111 (WB receives a bubble).
  3. FSM==BUSY, or FSM==IDLE with ex_div_start=1 → stall=001111 (MEM receives a bubble). The start cycle itself stalls.
  4. id_stallreq=1 → stall=000111 (EX receives a bubble).
  5. Otherwise stall=000000.
- Vector is always thermometer-coded from bit 0; no other patterns are legal.
- flush is combinational, equal to flush_req (0 in reset).
- Latency: a divide holds EX for exactly DIV_CYCLES+1 stall cycles (start cycle plus BUSY cycles) when no mem stall is present. DONE is the release cycle (stall=0 unless mem/id requests are active).
- Back-to-back divides: after DONE→IDLE, a new ex_div_start in the next cycle restarts BUSY normally.
- Simultaneous requests: id_stallreq during BUSY is masked by the EX stall, because the ID instruction is already stopped.
- Reset asserted mid-BUSY: the divide is abandoned immediately; no div_ready pulse.

Optional Feature:
- Macro PIPE_STALL_PERF_EN.
- When defined:
  - Adds three 32-bit saturating counters: perf_div_stall, perf_mem_stall, perf_lu_stall.
  - Each increments on cycles where its source is the winning stall cause under the priority above.
  - Counters are output as extra ports and cleared by resetn.
  - They hold at 32'hFFFF_FFFF.
- When undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines header (existing `lib/defines.vh`) supplies `StallBus`, `Stop`/`NoStop`, and new localparam encodings for the FSM states (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the stall patterns.
- One natural sub-module: div_seq_fsm (FSM plus div_cnt). The top-level module holds the priority stall encoder and the optional perf counters.

Test Plan:
- Reset: hold resetn=0 with all requests=1 → stall=000000, flush=0, div_ready=0. Release → IDLE, div_cnt=0.
- Single divide with DIV_CYCLES=32: pulse-hold ex_div_start → stall=001111 for 33 cycles, div_ready=1 for exactly 1 cycle with stall=000000, then FSM=IDLE.
- Divide plus mem stall: mem_stallreq=1 from BUSY count 30 to 5 cycles after completion → stall=011111 throughout, div_ready held high while mem_stallreq=1, drops 1 cycle after mem_stallreq falls.
- Flush mid-divide: flush_req at div_cnt=10 → same cycle stall=000000 and flush=1; next cycle FSM=IDLE, div_cnt=0; no div_ready pulse.
- Load-use alone → stall=000111 for 1 cycle. Load-use together with BUSY → stall=001111.
- PIPE_STALL_PERF_EN: one 32-cycle divide plus 4 mem-stall cycles → perf_div_stall=33, perf_mem_stall=4. Force a counter to FFFF_FFFF → it stays FFFF_FFFF.
